// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned PC_W = 32;
  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    PCTRL_RUN       = 2'd0,
    PCTRL_MDWAIT    = 2'd1,
    PCTRL_FLUSHWAIT = 2'd2
  } pctrl_state_e;

  // Hold vectors: [0] PC, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb
  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_MEM  = 5'b01111;
  localparam logic [4:0] STALL_EX   = 5'b00111;
  localparam logic [4:0] STALL_ID   = 5'b00011;
  localparam logic [4:0] STALL_IF   = 5'b00001;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall requests in, hold/bubble/redirect controls and counters out.
interface pipe_ctrl_if #(parameter int unsigned CNT_W = 32);
  import pipe_ctrl_pkg::*;

  logic             if_req_stall;
  logic             id_load_use;
  logic             ex_md_start;
  logic             ex_md_done;
  logic             ex_redirect;
  pc_t              ex_redirect_pc;
  logic             mem_req_stall;
  logic [4:0]       stall_ctrl;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_mem_bubble;
  logic             mem_wb_bubble;
  logic             pc_redirect_valid;
  pc_t              pc_redirect_pc;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    input  if_req_stall, id_load_use, ex_md_start, ex_md_done,
           ex_redirect, ex_redirect_pc, mem_req_stall,
    output stall_ctrl, if_id_flush, id_ex_bubble, ex_mem_bubble,
           mem_wb_bubble, pc_redirect_valid, pc_redirect_pc,
           stall_cycles, redirect_cnt
  );

  modport slave (
    output if_req_stall, id_load_use, ex_md_start, ex_md_done,
           ex_redirect, ex_redirect_pc, mem_req_stall,
    input  stall_ctrl, if_id_flush, id_ex_bubble, ex_mem_bubble,
           mem_wb_bubble, pc_redirect_valid, pc_redirect_pc,
           stall_cycles, redirect_cnt
  );

endinterface

// File: rtl/pctrl_perf_cnt.sv
// Wrap-around counters of stalled cycles and accepted redirects.
module pctrl_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall_any,
  input  logic             i_redirect_acc,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_redirect_cnt
);

  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_redirect_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (i_stall_any)    r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (i_redirect_acc) r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_redirect_cnt = r_redirect_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority mux plus mul/div and wrong-path FSM.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.master   bus
);

  pctrl_state_e r_state;
  pctrl_state_e w_next;
  logic [4:0]   w_stall;
  logic         w_flush;
  logic         w_idex_bubble;
  logic         w_exmem_bubble;
  logic         w_memwb_bubble;
  logic         w_redirect_acc;
  logic         w_stall_any;
  logic [CNT_W-1:0] w_stall_cycles;
  logic [CNT_W-1:0] w_redirect_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= PCTRL_RUN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_stall        = STALL_NONE;
    w_flush        = 1'b0;
    w_idex_bubble  = 1'b0;
    w_exmem_bubble = 1'b0;
    w_memwb_bubble = 1'b0;
    w_redirect_acc = 1'b0;
    if (!rst) begin
      if (bus.mem_req_stall) begin
        // MEM stall freezes the FSM; only the wrong-path wait may still retire
        w_stall        = STALL_MEM;
        w_memwb_bubble = 1'b1;
        if (r_state == PCTRL_FLUSHWAIT) begin
          w_flush = 1'b1;
          if (!bus.if_req_stall) w_next = PCTRL_RUN;
        end
      end else if (r_state == PCTRL_FLUSHWAIT) begin
        w_flush = 1'b1;
        if (bus.id_load_use) begin
          w_stall       = STALL_ID;
          w_idex_bubble = 1'b1;
        end else begin
          w_stall = STALL_IF;
        end
        if (!bus.if_req_stall) w_next = PCTRL_RUN;
      end else if ((r_state == PCTRL_MDWAIT && !bus.ex_md_done) ||
                   (r_state == PCTRL_RUN && bus.ex_md_start && !bus.ex_md_done)) begin
        w_stall        = STALL_EX;
        w_exmem_bubble = 1'b1;
        w_next         = PCTRL_MDWAIT;
      end else begin
        // Divider completion falls through to the lower-priority rules
        if (r_state == PCTRL_MDWAIT) w_next = PCTRL_RUN;
        if (bus.ex_redirect && r_state == PCTRL_RUN) begin
          w_redirect_acc = 1'b1;
          w_flush        = 1'b1;
          w_idex_bubble  = 1'b1;
          if (bus.if_req_stall) w_next = PCTRL_FLUSHWAIT;
        end else if (bus.id_load_use) begin
          w_stall       = STALL_ID;
          w_idex_bubble = 1'b1;
        end else if (bus.if_req_stall) begin
          w_stall = STALL_IF;
          w_flush = 1'b1;
        end
      end
    end
  end

  assign w_stall_any = |w_stall;

  pctrl_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk            (clk),
    .rst            (rst),
    .i_stall_any    (w_stall_any),
    .i_redirect_acc (w_redirect_acc),
    .o_stall_cycles (w_stall_cycles),
    .o_redirect_cnt (w_redirect_cnt)
  );

  assign bus.stall_ctrl        = w_stall;
  assign bus.if_id_flush       = w_flush;
  assign bus.id_ex_bubble      = w_idex_bubble;
  assign bus.ex_mem_bubble     = w_exmem_bubble;
  assign bus.mem_wb_bubble     = w_memwb_bubble;
  assign bus.pc_redirect_valid = w_redirect_acc;
  assign bus.pc_redirect_pc    = w_redirect_acc ? bus.ex_redirect_pc : '0;
  assign bus.stall_cycles      = w_stall_cycles;
  assign bus.redirect_cnt      = w_redirect_cnt;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the five-stage pipeline. It merges stall requests from IF, ID, EX (multi-cycle mul/div) and MEM with the branch/jump redirect resolved in EX. It drives the per-register `stall_ctrl` vector, the bubble/flush strobes consumed by the if_id/id_ex/ex_mem/mem_wb registers, and the PC redirect. A small FSM tracks multi-cycle divider waits and wrong-path fetch squashing; two counters record stall cycles and redirects.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `if_req_stall` in 1: fetch not ready (icache/bus wait).
- `id_load_use` in 1: ID source depends on a load currently in EX.
- `ex_md_start` in 1: mul/div instruction present in EX.
- `ex_md_done` in 1: mul/div result valid; level, held until the controller leaves MD_WAIT.
- `ex_redirect` in 1: taken branch/jump resolved in EX.
- `ex_redirect_pc` in `ysyx22040228_PCBUS`: redirect target.
- `mem_req_stall` in 1: data access not complete.
- `stall_ctrl` out 5: hold per register, 1 = hold. [0] PC, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb.
- `if_id_flush` out 1: load bubble into if_id.
- `id_ex_bubble` out 1: load bubble into id_ex.
- `ex_mem_bubble` out 1: load bubble into ex_mem.
- `mem_wb_bubble` out 1: load bubble into mem_wb.
- `pc_redirect_valid` out 1: one-cycle redirect strobe to PC generation.
- `pc_redirect_pc` out `ysyx22040228_PCBUS`: target; equals `ex_redirect_pc` when valid, otherwise 0.
- `stall_cycles` out `CNT_W`: count of cycles with `stall_ctrl != 0`.
- `redirect_cnt` out `CNT_W`: count of accepted redirects.

## Operation
- FSM states:
  - RUN.
  - MD_WAIT: EX is holding an unfinished mul/div.
  - FLUSH_WAIT: a wrong-path fetch is still in flight after a redirect.
- Per-cycle priority, highest first. Unlisted outputs are 0.
  1. `mem_req_stall`: `stall_ctrl=5'b01111`, `mem_wb_bubble=1`. No FSM transition except FLUSH_WAIT exit. Redirect and md_start are not accepted.
  2. MD_WAIT with `!ex_md_done`, or RUN with `ex_md_start && !ex_md_done`: `stall_ctrl=5'b00111`, `ex_mem_bubble=1`. RUN moves to MD_WAIT.
  3. MD_WAIT with `ex_md_done`: go to RUN. Outputs fall through to the rules below.
  4. `ex_redirect` in RUN (accepted):
     - `pc_redirect_valid=1`, `if_id_flush=1`, `id_ex_bubble=1`, `stall_ctrl=0`.
     - `id_load_use` and `if_req_stall` are ignored this cycle.
     - If `if_req_stall=1`, go to FLUSH_WAIT.
     - `redirect_cnt` +1.
  5. `id_load_use`: `stall_ctrl=5'b00011`, `id_ex_bubble=1`.
  6. `if_req_stall`: `stall_ctrl=5'b00001`, `if_id_flush=1`.
  7. Otherwise all outputs 0.
- FLUSH_WAIT:
  - `if_id_flush=1` every cycle, including under a MEM stall.
  - `stall_ctrl[0]=1`, OR-ed with rule 1.
  - Exit to RUN in the first cycle with `if_req_stall=0`; flush stays asserted in that cycle.
- RUN with `ex_md_start && ex_md_done` in the same cycle: no stall.
- `ex_redirect` and `ex_md_start` are never both high; `ex_redirect` is ignored in MD_WAIT and FLUSH_WAIT.
- Counters wrap modulo 2^CNT_W.

## Timing
- All strobes and `stall_ctrl` are combinational from current state and inputs, effective at the same clock edge.
- State and counters update at the next posedge.
- While `rst=1`: all combinational outputs are forced to 0. At the reset edge: state becomes RUN and both counters become 0.
- Reset mid-MD_WAIT or mid-FLUSH_WAIT returns to RUN with no pending redirect.
- Redirect latency: `pc_redirect_valid` is asserted in the same cycle `ex_redirect` is accepted. A redirect blocked by a MEM stall is accepted in the first unstalled cycle, since EX holds the branch.
- `pc_redirect_valid` is never high for two consecutive cycles for the same EX instruction.

## Structure
- Shared package / `defines.v`:
  - State encodings `PCTRL_RUN=2'd0`, `PCTRL_MDWAIT=2'd1`, `PCTRL_FLUSHWAIT=2'd2`.
  - Stall vector constants `STALL_MEM=5'b01111`, `STALL_EX=5'b00111`, `STALL_ID=5'b00011`, `STALL_IF=5'b00001`.
- One sub-module, `pctrl_perf_cnt`: the two wrap-around counters, enabled by `stall_any` and the redirect-accept strobe.
- The FSM and priority mux stay in `pipe_ctrl`.

## Test plan
- Reset: hold `rst` 2 cycles with `mem_req_stall=1` -> all outputs 0 and counters 0; after release, `stall_ctrl=5'b01111`.
- Load-use: `id_load_use=1` for 1 cycle -> `stall_ctrl=5'b00011`, `id_ex_bubble=1`; next cycle all 0; `stall_cycles=1`.
- Mul/div:
  - `ex_md_start=1`, with `ex_md_done` rising 4 cycles later -> 4 cycles of `stall_ctrl=5'b00111`/`ex_mem_bubble=1`, then RUN.
  - With `mem_req_stall=1` in the done cycle -> MD_WAIT held one more cycle.
- Redirect under MEM stall: `ex_redirect=1`, target 0x8000_0100, `mem_req_stall=1` for 3 cycles -> no `pc_redirect_valid` for 3 cycles, then exactly one pulse with that target; `redirect_cnt=1`.
- Wrong-path squash: redirect accepted with `if_req_stall=1` held 5 cycles -> `if_id_flush=1` for all 5 cycles plus the release cycle, `stall_ctrl[0]=1` throughout, then RUN.
- Priority: `id_load_use=1` and `if_req_stall=1` together -> `stall_ctrl=5'b00011`, `if_id_flush=0`.
